// File: rtl/draw_field_pkg.sv
// Shared types and helpers for the playfield raster tracker.
// Latency: none (declarations only).
// Backpressure: none.
package draw_field_pkg;

   // Tracker phase along one axis of a field
   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_BORDER = 2'd1,
      PH_BRICK  = 2'd2
   } phase_t;

   // Field extent along one axis: CNT bricks separated and enclosed by borders
   function automatic int unsigned field_extent(input int unsigned border,
                                                input int unsigned brick,
                                                input int unsigned cnt);
      return border * (cnt + 1) + brick * cnt;
   endfunction

   // Index width that never collapses to zero bits
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/draw_field_axis_tracker.sv
// Walks one axis of a field: border/brick phase counter plus brick index counter.
// Latency: state reflects the qualifying pixel one clock after load/step/clear.
// Backpressure: none; state holds whenever load, step and clear are all low.
module draw_field_axis_tracker
   import draw_field_pkg::*;
#(
   parameter int unsigned BORDER = 2,
   parameter int unsigned BRICK  = 20,
   parameter int unsigned CNT    = 10,
   parameter int unsigned IDX_W  = clog2_min1(CNT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             clear,
   output logic             active,
   output logic             in_brick,
   output logic [IDX_W-1:0] idx
);

   localparam int unsigned PH_W  = clog2_min1((BORDER > BRICK) ? BORDER : BRICK);
   localparam int unsigned CNT_W = clog2_min1(CNT + 1);

   phase_t          phase, phase_nxt;
   logic [PH_W-1:0] ph_cnt, ph_cnt_nxt;
   logic [CNT_W-1:0] bidx, bidx_nxt;

   // Next offset: load restarts at the leading border, step walks border/brick phases
   always_comb begin
      phase_nxt  = phase;
      ph_cnt_nxt = ph_cnt;
      bidx_nxt   = bidx;
      if (load) begin
         phase_nxt  = PH_BORDER;
         ph_cnt_nxt = '0;
         bidx_nxt   = '0;
      end else if (clear) begin
         phase_nxt = PH_IDLE;
      end else if (step) begin
         case (phase)
            PH_BORDER: begin
               if (ph_cnt == PH_W'(BORDER - 1)) begin
                  ph_cnt_nxt = '0;
                  // The border after the last brick closes the field
                  phase_nxt  = (bidx == CNT_W'(CNT)) ? PH_IDLE : PH_BRICK;
               end else begin
                  ph_cnt_nxt = ph_cnt + PH_W'(1);
               end
            end
            PH_BRICK: begin
               if (ph_cnt == PH_W'(BRICK - 1)) begin
                  ph_cnt_nxt = '0;
                  bidx_nxt   = bidx + CNT_W'(1);
                  phase_nxt  = PH_BORDER;
               end else begin
                  ph_cnt_nxt = ph_cnt + PH_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Tracker state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase  <= PH_IDLE;
         ph_cnt <= '0;
         bidx   <= '0;
      end else begin
         phase  <= phase_nxt;
         ph_cnt <= ph_cnt_nxt;
         bidx   <= bidx_nxt;
      end
   end

   assign active   = (phase != PH_IDLE);
   assign in_brick = (phase == PH_BRICK);
   assign idx      = bidx[IDX_W-1:0];

endmodule

// File: rtl/draw_field_tracker.sv
// Classifies each raster pixel against FIELD_CNT brick playfields (field/brick/col/row).
// Latency: fixed 2 clocks from pix_valid_i/pix_*_i to all outputs.
// Backpressure: none; pix_valid_i low freezes tracker state and yields zero outputs.
module draw_field_tracker
   import draw_field_pkg::*;
#(
   parameter int unsigned PIX_WIDTH   = 12,
   parameter int unsigned BRICK_X     = 20,
   parameter int unsigned BRICK_Y     = 25,
   parameter int unsigned BRICK_X_CNT = 10,
   parameter int unsigned BRICK_Y_CNT = 20,
   parameter int unsigned BORDER_X    = 2,
   parameter int unsigned BORDER_Y    = 2,
   parameter int unsigned FIELD_CNT   = 2,
   localparam int unsigned ID_W  = clog2_min1(FIELD_CNT),
   localparam int unsigned COL_W = clog2_min1(BRICK_X_CNT),
   localparam int unsigned ROW_W = clog2_min1(BRICK_Y_CNT)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [FIELD_CNT-1:0][PIX_WIDTH-1:0] start_x_i,
   input  logic [FIELD_CNT-1:0][PIX_WIDTH-1:0] start_y_i,
   input  logic                                pix_valid_i,
   input  logic [PIX_WIDTH-1:0]                pix_x_i,
   input  logic [PIX_WIDTH-1:0]                pix_y_i,
   output logic [FIELD_CNT-1:0]                in_field_o,
   output logic [FIELD_CNT-1:0]                in_brick_o,
   output logic                                hit_o,
   output logic [ID_W-1:0]                     field_id_o,
   output logic [COL_W-1:0]                    brick_col_num_o,
   output logic [ROW_W-1:0]                    brick_row_num_o,
   output logic                                pix_valid_o
);

   logic                                frame_start;
   logic                                x_cont;
   logic [FIELD_CNT-1:0][PIX_WIDTH-1:0] org_x_q, org_y_q, org_x, org_y;
   logic [PIX_WIDTH-1:0]                prev_x;
   logic                                vld_s1;
   logic [FIELD_CNT-1:0]                x_act, y_act, x_brk, y_brk;
   logic [COL_W-1:0]                    col [FIELD_CNT];
   logic [ROW_W-1:0]                    row [FIELD_CNT];
   logic [FIELD_CNT-1:0]                fld, brk;
   logic [ID_W-1:0]                     sel_id;
   logic [COL_W-1:0]                    sel_col;
   logic [ROW_W-1:0]                    sel_row;

   assign frame_start = pix_valid_i && (pix_x_i == '0) && (pix_y_i == '0);
   // The frame-start pixel itself already sees the new origins
   assign org_x  = frame_start ? start_x_i : org_x_q;
   assign org_y  = frame_start ? start_y_i : org_y_q;
   assign x_cont = (pix_x_i == prev_x + PIX_WIDTH'(1));

   // Latch field origins only at frame start; previous x for continuity checks
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         org_x_q <= '0;
         org_y_q <= '0;
         prev_x  <= '0;
      end else begin
         if (frame_start) begin
            org_x_q <= start_x_i;
            org_y_q <= start_y_i;
         end
         if (pix_valid_i) begin
            prev_x <= pix_x_i;
         end
      end
   end

   for (genvar f = 0; f < FIELD_CNT; f++) begin : g_field
      logic x_load, x_step, x_clear, y_load, y_step;

      assign x_load  = pix_valid_i && (pix_x_i == org_x[f]);
      assign x_step  = pix_valid_i && !x_load && x_cont;
      assign x_clear = pix_valid_i && !x_load && !x_cont;
      // Rows move once per line, on the field's left-edge pixel
      assign y_load  = x_load && (pix_y_i == org_y[f]);
      assign y_step  = x_load && !y_load;

      draw_field_axis_tracker #(
         .BORDER (BORDER_X),
         .BRICK  (BRICK_X),
         .CNT    (BRICK_X_CNT),
         .IDX_W  (COL_W)
      ) u_x (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (x_load),
         .step     (x_step),
         .clear    (x_clear),
         .active   (x_act[f]),
         .in_brick (x_brk[f]),
         .idx      (col[f])
      );

      draw_field_axis_tracker #(
         .BORDER (BORDER_Y),
         .BRICK  (BRICK_Y),
         .CNT    (BRICK_Y_CNT),
         .IDX_W  (ROW_W)
      ) u_y (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (y_load),
         .step     (y_step),
         .clear    (1'b0),
         .active   (y_act[f]),
         .in_brick (y_brk[f]),
         .idx      (row[f])
      );
   end

   // Lowest-index field wins; col/row reported only inside a brick
   always_comb begin
      fld     = '0;
      brk     = '0;
      sel_id  = '0;
      sel_col = '0;
      sel_row = '0;
      if (vld_s1) begin
         fld = x_act & y_act;
         brk = fld & x_brk & y_brk;
         for (int f = FIELD_CNT - 1; f >= 0; f--) begin
            if (fld[f]) begin
               sel_id  = ID_W'(f);
               sel_col = brk[f] ? col[f] : '0;
               sel_row = brk[f] ? row[f] : '0;
            end
         end
      end
   end

   // Second pipeline stage: register qualified results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_s1          <= 1'b0;
         pix_valid_o     <= 1'b0;
         in_field_o      <= '0;
         in_brick_o      <= '0;
         hit_o           <= 1'b0;
         field_id_o      <= '0;
         brick_col_num_o <= '0;
         brick_row_num_o <= '0;
      end else begin
         vld_s1          <= pix_valid_i;
         pix_valid_o     <= vld_s1;
         in_field_o      <= fld;
         in_brick_o      <= brk;
         hit_o           <= |fld;
         field_id_o      <= sel_id;
         brick_col_num_o <= sel_col;
         brick_row_num_o <= sel_row;
      end
   end

endmodule
